// File: rtl/if_prefetch_pkg.sv
// if_prefetch_pkg: default widths and counter sizing shared by the fetch unit
package if_prefetch_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_PC_WIDTH = 32;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/if_fifo.sv
// if_fifo: synchronous FIFO with flush, count, empty and full
module if_fifo
  import if_prefetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign dout = mem[rd];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr] <= din;
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: decoupled instruction fetcher with credit-limited prefetch FIFO and redirect flush
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int PC_WIDTH = DEF_PC_WIDTH,
  parameter int DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pcsrc,
  input  logic [PC_WIDTH-1:0] pctarget,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [XLEN-1:0]     imem_rdata,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [XLEN-1:0]     instruction,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pcplus4
);
  localparam int CW = cnt_w(DEPTH);
  logic [PC_WIDTH-1:0] fetch_pc, resp_pc, tgt;
  logic [CW-1:0] outst, discard, count;
  logic [CW:0] credits;
  logic empty, full, pop, push, rsp, issue;
  logic [PC_WIDTH+XLEN-1:0] head;
  assign tgt = pctarget & ~PC_WIDTH'(3);
  assign pop = inst_valid && inst_ready;
  assign credits = (CW+1)'(count) + (CW+1)'(outst) - (CW+1)'(pop);
  assign imem_req = rst_n && !pcsrc && credits < (CW+1)'(DEPTH);
  assign imem_addr = fetch_pc;
  assign issue = imem_req && imem_gnt;
  // outstanding includes in-flight words already marked for discard
  assign rsp = imem_rvalid && outst != '0;
  assign push = rsp && discard == '0 && !pcsrc && !full;
  assign inst_valid = !empty && !pcsrc;
  assign {pc, instruction} = head;
  assign pcplus4 = pc + PC_WIDTH'(4);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outst <= '0;
      discard <= '0;
    end else begin
      outst <= outst + CW'(issue) - CW'(rsp);
      if (pcsrc) begin
        fetch_pc <= tgt;
        resp_pc <= tgt;
        discard <= outst - CW'(rsp);
      end else begin
        if (issue) fetch_pc <= fetch_pc + PC_WIDTH'(4);
        if (rsp && discard != '0) discard <= discard - CW'(1);
        if (push) resp_pc <= resp_pc + PC_WIDTH'(4);
      end
    end
  if_fifo #(.WIDTH(PC_WIDTH + XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(pcsrc),
    .push(push),
    .pop(pop),
    .din({resp_pc, imem_rdata}),
    .dout(head),
    .count(count),
    .empty(empty),
    .full(full)
  );
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed phases plus random traffic against an in-order fetch-stream reference
module tb_if_prefetch;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic clk = 0, rst_n = 0, pcsrc = 0, imem_gnt = 0, imem_rvalid = 0, inst_ready = 0;
  logic [31:0] pctarget = '0, imem_rdata = '0;
  logic imem_req, inst_valid;
  logic [31:0] imem_addr, instruction, pc, pcplus4;
  always #5 clk = ~clk;
  if_prefetch #(.XLEN(32), .PC_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .pcsrc(pcsrc), .pctarget(pctarget),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .pc(pc), .pcplus4(pcplus4)
  );
  typedef struct {int due; logic [31:0] addr; bit stale;} req_t;
  req_t q[$];
  int ncmp = 0, nfail = 0, cyc = 0, last_due = 0, buffered = 0, ngrant = 0, npop = 0, nredir_rv = 0;
  int gmode = 0, rmode = 0, lat_lo = 1, lat_hi = 1;
  logic [31:0] exp_fetch = RESET_PC, exp_pc = RESET_PC, key = '0, tgt_v = '0;
  bit pcsrc_v = 0, redir_if_rv = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    ncmp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, o, e, cyc);
    end
  endtask

  task automatic step();
    bit rv, ev, pe;
    req_t it;
    int d;
    @(negedge clk);
    rst_n = 1;
    cyc++;
    rv = q.size() > 0 && q[0].due <= cyc;
    pcsrc = pcsrc_v || (redir_if_rv && rv);
    if (redir_if_rv && rv) begin
      redir_if_rv = 0;
      nredir_rv++;
    end
    pctarget = tgt_v;
    imem_rvalid = rv;
    imem_rdata = rv ? q[0].addr ^ key : $urandom;
    imem_gnt = gmode == 0 ? 1'b1 : gmode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    inst_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    ev = buffered > 0 && !pcsrc;
    pe = ev && inst_ready;
    chk("inst_valid", 32'(inst_valid), 32'(ev));
    chk("imem_req", 32'(imem_req), 32'(!pcsrc && (buffered + q.size() - int'(pe)) < DEPTH));
    chk("imem_addr", imem_addr, exp_fetch);
    if (ev) begin
      chk("pc", pc, exp_pc);
      chk("instruction", instruction, exp_pc ^ key);
      chk("pcplus4", pcplus4, exp_pc + 32'd4);
    end
    if (rv) begin
      it = q.pop_front();
      if (!it.stale && !pcsrc) buffered++;
    end
    if (imem_req && imem_gnt) begin
      d = cyc + int'($urandom_range(lat_lo, lat_hi));
      if (d < last_due) d = last_due;
      last_due = d;
      q.push_back('{d, imem_addr, 1'b0});
      exp_fetch += 32'd4;
      ngrant++;
    end
    if (pe) begin
      buffered--;
      exp_pc += 32'd4;
      npop++;
    end
    if (pcsrc) begin
      buffered = 0;
      foreach (q[i]) q[i].stale = 1;
      exp_fetch = tgt_v & ~32'h3;
      exp_pc = exp_fetch;
    end
  endtask

  // reset lands between clock edges; outputs are checked before any edge occurs
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 0;
    pcsrc = 0;
    imem_gnt = 0;
    imem_rvalid = 0;
    inst_ready = 0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_pcplus4", pcplus4, 32'd4);
    q.delete();
    buffered = 0;
    last_due = cyc;
    exp_fetch = RESET_PC;
    exp_pc = RESET_PC;
    pcsrc_v = 0;
    redir_if_rv = 0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    do_reset();
    npop = 0;
    repeat (20) step();
    chk("stream_pops", npop, 18);
    do_reset();
    rmode = 2;
    ngrant = 0;
    repeat (10) step();
    chk("bp_grants", ngrant, 4);
    chk("bp_req_off", 32'(imem_req), 32'd0);
    chk("bp_head_pc", pc, 32'd0);
    rmode = 0;
    npop = 0;
    repeat (8) step();
    chk("bp_drained", 32'(npop >= 4), 32'd1);
    do_reset();
    lat_lo = 3;
    lat_hi = 3;
    repeat (2) step();
    pcsrc_v = 1;
    tgt_v = 32'h100;
    step();
    pcsrc_v = 0;
    npop = 0;
    repeat (12) step();
    chk("redir_delivered", 32'(npop >= 2), 32'd1);
    pcsrc_v = 1;
    tgt_v = 32'hFFFF_FFFE;
    step();
    pcsrc_v = 0;
    repeat (12) step();
    lat_lo = 1;
    lat_hi = 2;
    tgt_v = 32'h3F0;
    nredir_rv = 0;
    redir_if_rv = 1;
    repeat (10) step();
    chk("simul_taken", nredir_rv, 1);
    repeat (10) step();
    gmode = 2;
    repeat (5) step();
    gmode = 0;
    pcsrc_v = 1;
    tgt_v = 32'h203;
    step();
    pcsrc_v = 0;
    npop = 0;
    repeat (10) step();
    chk("stall_redir_pops", 32'(npop >= 2), 32'd1);
    gmode = 1;
    rmode = 1;
    lat_lo = 1;
    lat_hi = 4;
    repeat (300) begin
      pcsrc_v = $urandom_range(0, 15) == 0;
      tgt_v = $urandom;
      step();
    end
    pcsrc_v = 0;
    do_reset();
    key = $urandom;
    gmode = 0;
    rmode = 0;
    lat_lo = 1;
    lat_hi = 1;
    npop = 0;
    repeat (10) step();
    chk("restart_pops", npop, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
